// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and divide (restoring on magnitudes) with HI/LO results.
// Optional divide-by-zero trap enabled by defining MULT_DIV_DIV_ZERO_TRAP_EN.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op_div,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [32:0] r_acc;
    logic [31:0] r_q;
    logic        r_q_m1;
    logic [31:0] r_m;
    logic        r_op_div;
    logic        r_a_neg;
    logic        r_b_neg;
    logic        r_b_zero;
    logic        r_trap;
    logic [5:0]  r_count;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_trap_start;
    logic        w_finish_exit;
    logic        w_busy_next;
    logic        w_done_next;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_m_ext;
    logic [32:0] w_booth_sum;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
    logic        r_div_zero;
    logic        w_div_zero_next;

    assign w_trap_start    = op_div && (b_in == 32'd0);
    assign w_div_zero_next = w_finish_exit && r_trap;
    assign div_zero        = r_div_zero;

    always_ff @(posedge clock) begin
        if (reset) r_div_zero <= 1'b0;
        else       r_div_zero <= w_div_zero_next;
    end
`else
    assign w_trap_start = 1'b0;
    assign div_zero     = 1'b0;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic; a trapped divide spends two cycles in FINISH so it completes at k+2
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = w_trap_start ? S_FINISH : S_RUN;
            S_RUN:    if (r_count == 6'd31) w_next_state = S_FINISH;
            S_FINISH: if (!(r_trap && r_count == 6'd0)) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output logic: values registered on the following edge
    always_comb begin
        w_finish_exit = (r_state == S_FINISH) && (w_next_state == S_IDLE);
        w_busy_next   = (w_next_state != S_IDLE);
        w_done_next   = w_finish_exit;
    end

    assign w_a_abs = a_in[31] ? (32'd0 - a_in) : a_in;
    assign w_b_abs = b_in[31] ? (32'd0 - b_in) : b_in;

    // Booth step: 33-bit accumulator so adding/subtracting -2^31 cannot overflow
    assign w_m_ext = {r_m[31], r_m};
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_q_m1})
            2'b01:   w_booth_sum = r_acc + w_m_ext;
            2'b10:   w_booth_sum = r_acc - w_m_ext;
            default: w_booth_sum = r_acc;
        endcase
    end

    assign w_div_shift = {r_acc[31:0], r_q[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_m});

    // Untrapped divide by zero reports an all-ones quotient regardless of dividend sign
    assign w_quot = r_b_zero ? 32'hFFFF_FFFF :
                    ((r_a_neg ^ r_b_neg) ? (32'd0 - r_q) : r_q);
    assign w_rem  = r_a_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_q_m1   <= 1'b0;
            r_m      <= '0;
            r_op_div <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_trap   <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_div <= op_div;
                        r_a_neg  <= a_in[31];
                        r_b_neg  <= b_in[31];
                        r_b_zero <= (b_in == 32'd0);
                        r_trap   <= w_trap_start;
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_q_m1   <= 1'b0;
                        r_q      <= op_div ? w_a_abs : a_in;
                        r_m      <= op_div ? w_b_abs : b_in;
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 6'd1;
                    if (r_op_div) begin
                        r_acc <= w_div_ge ? (w_div_shift - {1'b0, r_m}) : w_div_shift;
                        r_q   <= {r_q[30:0], w_div_ge};
                    end else begin
                        {r_acc, r_q, r_q_m1} <= {w_booth_sum[32], w_booth_sum, r_q};
                    end
                end
                S_FINISH: begin
                    if (!w_finish_exit) begin
                        r_count <= r_count + 6'd1;
                    end else if (!r_trap) begin
                        r_hi <= r_op_div ? w_rem  : r_acc[31:0];
                        r_lo <= r_op_div ? w_quot : r_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: products, quotients, latency, busy/done
// behaviour, ignored starts, back-to-back, mid-operation reset and divide by zero.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op_div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_cmp;
    int n_err;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op_div   (op_div),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    // Count done pulses over n cycles with start held low
    task automatic watch_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) cnt++;
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after the budget).
    // lat counts edges after the accepting edge; pulses injects starts at cycles 5 and 20.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input bit pulses, output int lat, output int busy_n);
        bit got;
        start  = 1'b1;
        op_div = op;
        a_in   = a;
        b_in   = b;
        @(posedge clock);
        @(negedge clock);
        lat = 0;
        busy_n = 0;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            start = pulses && (i == 5 || i == 20);
            if (start) begin
                op_div = 1'b0;
                a_in   = 32'd3;
                b_in   = 32'd3;
            end
            if (busy) busy_n++;
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (done) got = 1;
        end
        start = 1'b0;
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    int lat;
    int busy_n;
    int cnt;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op_div = 1'b0;
        a_in   = '0;
        b_in   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dz",   {63'd0, div_zero}, 64'd0);
        check("rst_hi",   {32'd0, hi_out}, 64'd0);
        check("rst_lo",   {32'd0, lo_out}, 64'd0);
        idle_cycles(3);
        check("idle_busy", {63'd0, busy}, 64'd0);

        // MULT 7 * -3 = -21
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, busy_n);
        check("m1_lat",  lat, 64'd33);
        check("m1_busy", busy_n, 64'd33);
        check("m1_hi",   {32'd0, hi_out}, 64'hFFFF_FFFF);
        check("m1_lo",   {32'd0, lo_out}, 64'hFFFF_FFEB);
        check("m1_dz",   {63'd0, div_zero}, 64'd0);
        idle_cycles(1);
        check("m1_done_width", {63'd0, done}, 64'd0);
        check("m1_busy_after", {63'd0, busy}, 64'd0);
        idle_cycles(4);
        check("m1_hold_hi", {32'd0, hi_out}, 64'hFFFF_FFFF);
        check("m1_hold_lo", {32'd0, lo_out}, 64'hFFFF_FFEB);

        // MULT -2^31 * -2^31 = 2^62
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, busy_n);
        check("m2_hi", {32'd0, hi_out}, 64'h4000_0000);
        check("m2_lo", {32'd0, lo_out}, 64'h0000_0000);
        idle_cycles(2);

        // DIV -7 / 2 = -3 rem -1
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, busy_n);
        check("d1_lat", lat, 64'd33);
        check("d1_lo",  {32'd0, lo_out}, 64'hFFFF_FFFD);
        check("d1_hi",  {32'd0, hi_out}, 64'hFFFF_FFFF);
        check("d1_dz",  {63'd0, div_zero}, 64'd0);
        idle_cycles(2);

        // DIV -2^31 / -1 wraps to -2^31, remainder 0
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, busy_n);
        check("d2_lo", {32'd0, lo_out}, 64'h8000_0000);
        check("d2_hi", {32'd0, hi_out}, 64'h0000_0000);
        check("d2_dz", {63'd0, div_zero}, 64'd0);
        idle_cycles(2);

        // MULT 1000 * -1000 with ignored starts, then back-to-back DIV 100 / 7
        run_op(1'b0, 32'd1000, 32'hFFFF_FC18, 1'b1, lat, busy_n);
        check("ign_lat", lat, 64'd33);
        check("ign_hi",  {32'd0, hi_out}, 64'hFFFF_FFFF);
        check("ign_lo",  {32'd0, lo_out}, 64'hFFF0_BDC0);
        run_op(1'b1, 32'd100, 32'd7, 1'b0, lat, busy_n);
        check("b2b_lat", lat, 64'd33);
        check("b2b_lo",  {32'd0, lo_out}, 64'd14);
        check("b2b_hi",  {32'd0, hi_out}, 64'd2);
        watch_done(40, cnt);
        check("b2b_extra_done", cnt, 64'd0);

        // Reset at iteration 10 of a DIV aborts it
        start  = 1'b1;
        op_div = 1'b1;
        a_in   = 32'd1234;
        b_in   = 32'd5;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        idle_cycles(10);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi",   {32'd0, hi_out}, 64'd0);
        check("abort_lo",   {32'd0, lo_out}, 64'd0);
        watch_done(40, cnt);
        check("abort_no_done", cnt, 64'd0);

        // Seed HI/LO, then DIV 5 / 0
        run_op(1'b0, 32'd6, 32'd7, 1'b0, lat, busy_n);
        check("seed_lo", {32'd0, lo_out}, 64'd42);
        idle_cycles(2);
        run_op(1'b1, 32'd5, 32'd0, 1'b0, lat, busy_n);
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
        check("dz_lat",  lat, 64'd2);
        check("dz_flag", {63'd0, div_zero}, 64'd1);
        check("dz_hi",   {32'd0, hi_out}, 64'd0);
        check("dz_lo",   {32'd0, lo_out}, 64'd42);
`else
        check("dz_lat",  lat, 64'd33);
        check("dz_flag", {63'd0, div_zero}, 64'd0);
        check("dz_hi",   {32'd0, hi_out}, 64'd5);
        check("dz_lo",   {32'd0, lo_out}, 64'hFFFF_FFFF);
`endif
        idle_cycles(1);
        check("dz_flag_width", {63'd0, div_zero}, 64'd0);
        check("dz_done_width", {63'd0, done}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL provide port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL provide port `start`, input, 1 bit: request from the control unit; sampled only in IDLE.
REQ-005 The block SHALL provide port `op_div`, input, 1 bit: 0 = signed MULT, 1 = signed DIV; sampled with `start`.
REQ-006 The block SHALL provide port `a_in`, input, 32 bits: rs operand (multiplicand or dividend); sampled with `start`.
REQ-007 The block SHALL provide port `b_in`, input, 32 bits: rt operand (multiplier or divisor); sampled with `start`.
REQ-008 The block SHALL provide port `busy`, output, 1 bit: registered; high in RUN and FINISH.
REQ-009 The block SHALL provide port `done`, output, 1 bit: registered; exactly one cycle wide per accepted `start`.
REQ-010 The block SHALL provide port `div_zero`, output, 1 bit: registered; one-cycle divide-by-zero flag, coincident with `done`.
REQ-011 The block SHALL provide port `hi_out`, output, 32 bits: HI register.
REQ-012 The block SHALL provide port `lo_out`, output, 32 bits: LO register.

Function
REQ-013 The block SHALL implement the states IDLE, RUN and FINISH; IDLE SHALL be the reset state.
REQ-014 In IDLE with `start`=1, the edge SHALL latch `op_div`, `a_in` and `b_in`, clear the 6-bit iteration counter, and go to RUN.
REQ-015 RUN SHALL perform one iteration per cycle, for exactly 32 iterations; after the 32nd iteration edge the state SHALL go to FINISH.
REQ-016 The FINISH edge SHALL write HI/LO, set `done`=1 for the next cycle, and return to IDLE.
REQ-017 Latency SHALL be: `start` accepted at edge k; HI/LO and `done` updated at edge k+33.
REQ-018 In IDLE, `start`=0 SHALL leave all state unchanged; `done` and `div_zero` SHALL be 0 outside their pulse cycle.
REQ-019 A `start` asserted while `busy`=1 SHALL be ignored; operands SHALL be neither relatched nor queued.
REQ-020 A `start` asserted in the cycle where `done`=1 SHALL be accepted, because the block is then in IDLE (back-to-back operation).
REQ-021 MULT SHALL produce the signed 64-bit product, with {HI,LO} = a*b (two's complement), e.g. radix-2 Booth.
REQ-022 DIV SHALL produce LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign (restoring division on magnitudes, then sign correction).
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000, with no flag.
REQ-024 HI/LO SHALL hold their values between completions and SHALL change only at the FINISH edge or on reset.

Reset
REQ-025 When `reset`=1 at an edge, the block SHALL go to IDLE and clear to 0: `busy`, `done`, `div_zero`, `hi_out`, `lo_out`, the counter and the operand registers.
REQ-026 Reset SHALL take priority over `start` and over any state.
REQ-027 A reset in RUN or FINISH SHALL abort the operation; no `done` SHALL be produced for the aborted operation.

Configuration
REQ-028 The divide-by-zero trap SHALL be controlled by the macro `MULT_DIV_DIV_ZERO_TRAP_EN`.
REQ-029 With `MULT_DIV_DIV_ZERO_TRAP_EN` defined, DIV with `b_in`=0 SHALL go IDLE->FINISH (no RUN).
REQ-030 In that case the FINISH edge SHALL set `done`=1 and `div_zero`=1, HI/LO SHALL be unchanged, and latency SHALL be 2 edges (k+2).
REQ-031 With `MULT_DIV_DIV_ZERO_TRAP_EN` undefined, `div_zero` SHALL be tied to 0.
REQ-032 In that case DIV by 0 SHALL run the full 33 cycles and write LO=0xFFFFFFFF and HI=a_in.

Verification
REQ-033 The bench SHALL cover: MULT a=7, b=-3 -> at edge k+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` for 1 cycle, `busy` high for 33 cycles.
REQ-034 The bench SHALL cover: MULT a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-035 The bench SHALL cover: DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); and DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
REQ-036 The bench SHALL cover: `start` pulsed at cycles 5 and 20 of a running MULT -> ignored; a single `done`; a `start` in the `done` cycle -> new operation completes 33 edges later.
REQ-037 The bench SHALL cover: `reset` at iteration 10 of DIV -> next cycle IDLE, HI=LO=0, and no `done` seen for 40 cycles.
REQ-038 The bench SHALL cover DIV a=5, b=0 in both builds: with the macro, `done`=`div_zero`=1 at edge k+2 and HI/LO unchanged; without it, `done` at k+33, LO=0xFFFFFFFF, HI=5, `div_zero`=0.
